// File: rtl/ling_pkg.sv
// Shared encodings and elaboration helpers for the pipelined sparse-4 Ling modular adder.
package ling_pkg;

  localparam logic LING_MODE_POW2 = 1'b0;
  localparam logic LING_MODE_EAC  = 1'b1;

  localparam int LING_MIN_WIDTH = 8;
  localparam int LING_MAX_WIDTH = 64;

  function automatic int ling_prefix_levels(input int width);
    return $clog2(width / 2);
  endfunction

  function automatic bit ling_width_ok(input int width);
    return (width % 8 == 0) && (width >= LING_MIN_WIDTH) && (width <= LING_MAX_WIDTH);
  endfunction

endpackage

// File: rtl/ling_sparse4_sum_group.sv
// Conditional 4-bit Ling sum: both carry-in cases are formed locally and the
// pseudo-carry H of the preceding sparse position selects one.
module ling_sparse4_sum_group (
  input  logic [3:0] x,
  input  logic [2:0] g,
  input  logic [3:0] p,     // p[0] is the transmit bit just below the group
  input  logic       h_in,
  output logic [3:0] sum
);

  logic [3:0] sum0;
  logic [3:0] sum1;
  logic       c0;
  logic       c1;

  always_comb begin
    c0 = 1'b0;
    c1 = p[0];
    sum0 = '0;
    sum1 = '0;
    for (int i = 0; i < 3; i++) begin
      sum0[i] = x[i] ^ c0;
      sum1[i] = x[i] ^ c1;
      c0 = g[i] | (p[i+1] & c0);
      c1 = g[i] | (p[i+1] & c1);
    end
    sum0[3] = x[3] ^ c0;
    sum1[3] = x[3] ^ c1;
    sum = h_in ? sum1 : sum0;
  end

endmodule

// File: rtl/ling_modadd_pipe.sv
// Pipelined sparse-4 Ling adder, mod 2^WIDTH or mod 2^WIDTH-1 per transaction.
// Optional LING_EAC_ZERO_NORM_EN maps the redundant all-ones EAC result to zero.
module ling_modadd_pipe
  import ling_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int NP     = WIDTH / 2;
  localparam int NG     = WIDTH / 4;
  localparam int LEVELS = ling_prefix_levels(WIDTH);
  localparam int W1     = 1 + WIDTH + 3 * NG + WIDTH + 2 * NP;
  localparam int W2     = 1 + WIDTH + 3 * NG + WIDTH + NG;

  if (!ling_width_ok(WIDTH) || STAGES < 1 || STAGES > 3) begin : g_bad_cfg
    $error("ling_modadd_pipe: unsupported WIDTH/STAGES");
  end

  // Valid/ready: a side transfers when valid && ready; a stage loads when it is
  // empty or its content leaves this cycle, so bubbles collapse and ready
  // depends only on out_ready and stored valids, never on in_valid.
  logic [STAGES-1:0] v_q, v_d, adv, en;
  logic [STAGES:0]   vchain;

  always_comb begin
    vchain = {v_q, in_valid};
    adv = '0;
    en  = '0;
    v_d = v_q;
    adv[STAGES-1] = !v_q[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) adv[k] = !v_q[k] || adv[k+1];
    for (int k = 0; k < STAGES; k++) begin
      en[k] = adv[k] && vchain[k];
      if (adv[k]) v_d[k] = vchain[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_q <= '0;
    else        v_q <= v_d;
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[STAGES-1];

  logic [WIDTH-1:0]  a_g, a_p, a_x;
  logic [3*NG-1:0]   a_gs;
  logic [NP-1:0]     a_h1, a_pr1;

  always_comb begin
    a_g = in_a & in_b;
    a_p = in_a | in_b;
    a_x = in_a ^ in_b;
    // The pair-0 transmit term reaches below bit 0: circular in EAC mode, cut otherwise.
    a_h1[0]  = a_g[1] | a_g[0];
    a_pr1[0] = a_p[0] & a_p[WIDTH-1] & (in_mode == LING_MODE_EAC);
    for (int j = 1; j < NP; j++) begin
      a_h1[j]  = a_g[2*j+1] | a_g[2*j];
      a_pr1[j] = a_p[2*j] & a_p[2*j-1];
    end
    for (int k = 0; k < NG; k++) a_gs[3*k +: 3] = a_g[4*k +: 3];
  end

  logic [W1-1:0] b1_in, b1_out;
  assign b1_in = {in_mode, a_x, a_gs, a_p, a_h1, a_pr1};

  if (STAGES >= 2) begin : g_reg1
    logic [W1-1:0] b1_q, b1_d;
    always_comb b1_d = en[0] ? b1_in : b1_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) b1_q <= '0;
      else        b1_q <= b1_d;
    end
    assign b1_out = b1_q;
  end else begin : g_wire1
    assign b1_out = b1_in;
  end

  logic              b_mode;
  logic [WIDTH-1:0]  b_x, b_p;
  logic [3*NG-1:0]   b_gs;
  logic [NP-1:0]     b_h1, b_pr1;
  assign {b_mode, b_x, b_gs, b_p, b_h1, b_pr1} = b1_out;

  logic [NP-1:0] hp, prp, hn, pn;
  logic [NG-1:0] b_hs;

  always_comb begin
    hp = b_h1;
    prp = b_pr1;
    hn = '0;
    pn = '0;
    for (int l = 0; l < LEVELS; l++) begin
      hn = hp;
      pn = prp;
      for (int j = (1 << l); j < NP; j++) begin
        hn[j] = hp[j] | (prp[j] & hp[j - (1 << l)]);
        pn[j] = prp[j] & prp[j - (1 << l)];
      end
      hp = hn;
      prp = pn;
    end
    // Only every 4th bit keeps an H; the top linear H wraps in through prp.
    for (int k = 0; k < NG; k++) b_hs[k] = hp[2*k+1] | (prp[2*k+1] & hp[NP-1]);
  end

  logic [W2-1:0] b2_in, b2_out;
  assign b2_in = {b_mode, b_x, b_gs, b_p, b_hs};

  if (STAGES == 3) begin : g_reg2
    logic [W2-1:0] b2_q, b2_d;
    always_comb b2_d = en[1] ? b2_in : b2_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) b2_q <= '0;
      else        b2_q <= b2_d;
    end
    assign b2_out = b2_q;
  end else begin : g_wire2
    assign b2_out = b2_in;
  end

  logic              c_mode, c_eac;
  logic [WIDTH-1:0]  c_x, c_p, c_sum;
  logic [3*NG-1:0]   c_gs;
  logic [NG-1:0]     c_hs, grp_h, grp_pm1;
  assign {c_mode, c_x, c_gs, c_p, c_hs} = b2_out;

  always_comb begin
    c_eac = (c_mode == LING_MODE_EAC);
    grp_h = '0;
    grp_pm1 = '0;
    grp_h[0]   = c_eac & c_hs[NG-1];
    grp_pm1[0] = c_eac & c_p[WIDTH-1];
    for (int k = 1; k < NG; k++) begin
      grp_h[k]   = c_hs[k-1];
      grp_pm1[k] = c_p[4*k-1];
    end
  end

  for (genvar k = 0; k < NG; k++) begin : g_grp
    ling_sparse4_sum_group u_grp (
      .x    (c_x[4*k +: 4]),
      .g    (c_gs[3*k +: 3]),
      .p    ({c_p[4*k +: 3], grp_pm1[k]}),
      .h_in (grp_h[k]),
      .sum  (c_sum[4*k +: 4])
    );
  end

  logic [WIDTH-1:0] res, sum_q, sum_d;
  logic             c_cout, cout_q, cout_d;

  always_comb begin
    res = c_sum;
`ifdef LING_EAC_ZERO_NORM_EN
    if (c_eac && (&c_sum)) res = '0;
`endif
    c_cout = (c_mode == LING_MODE_POW2) & c_p[WIDTH-1] & c_hs[NG-1];
    sum_d  = sum_q;
    cout_d = cout_q;
    if (en[STAGES-1]) begin
      sum_d  = res;
      cout_d = c_cout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;

endmodule

// File: tb/tb_ling_modadd_pipe.sv
// Bench: directed checks on a 16-bit/2-stage instance plus concurrent random
// streams on several WIDTH/STAGES instances against an arithmetic model.
module tb_ling_modadd_pipe;

  localparam int NRAND = 2500;
  localparam int RW[4] = '{8, 32, 64, 64};
  localparam int RS[4] = '{1, 3, 1, 3};

`ifdef LING_EAC_ZERO_NORM_EN
  localparam logic [15:0] EXP_EAC_ZERO = 16'h0000;
`else
  localparam logic [15:0] EXP_EAC_ZERO = 16'hFFFF;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_n_dir;
  int n_total = 0;
  int n_bad = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic mark_done();
    done_cnt++;
  endtask

  // Returns {cout, sum}; sum occupies the low w bits.
  function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic mode, input int w);
    logic [64:0] mask, s, r;
    mask = (65'd1 << w) - 65'd1;
    s = ({1'b0, a} & mask) + ({1'b0, b} & mask);
    if (!mode) begin
      r = s & mask;
      r[64] = s[w];
    end else begin
      r = (s & mask) + (s >> w);
`ifdef LING_EAC_ZERO_NORM_EN
      if (r == mask) r = '0;
`endif
      r[64] = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [16:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic mode);
    logic [64:0] r;
    r = ref_add({48'd0, a}, {48'd0, b}, mode, 16);
    return {r[64], r[15:0]};
  endfunction

  // ---------------- directed instance ----------------
  logic        d_in_valid, d_in_ready, d_mode, d_out_valid, d_out_ready, d_cout;
  logic [15:0] d_a, d_b, d_sum;

  ling_modadd_pipe #(.WIDTH(16), .STAGES(2)) u_dir (
    .clk       (clk),
    .rst_n     (rst_n_dir),
    .in_valid  (d_in_valid),
    .in_ready  (d_in_ready),
    .in_a      (d_a),
    .in_b      (d_b),
    .in_mode   (d_mode),
    .out_valid (d_out_valid),
    .out_ready (d_out_ready),
    .out_sum   (d_sum),
    .out_cout  (d_cout)
  );

  task automatic dir_txn(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic mode, input logic [15:0] es, input logic ec);
    @(negedge clk);
    d_a = a; d_b = b; d_mode = mode; d_in_valid = 1'b1; d_out_ready = 1'b1;
    #1 check({tag, "_rdy"}, d_in_ready, 1);
    @(negedge clk);
    d_in_valid = 1'b0;
    #1 check({tag, "_lat1"}, d_out_valid, 0);
    @(negedge clk);
    #1 check({tag, "_lat2"}, d_out_valid, 1);
    check({tag, "_sum"}, d_sum, es);
    check({tag, "_cout"}, d_cout, ec);
  endtask

  // ---------------- random instances ----------------
  for (genvar ci = 0; ci < 4; ci++) begin : g_rand
    localparam int W = RW[ci];
    localparam int S = RS[ci];
    logic         iv, ir, im, ov, out_rdy, oc;
    logic [W-1:0] ia, ib, os;
    logic [W:0]   exp_q[$];

    ling_modadd_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv),
      .in_ready  (ir),
      .in_a      (ia),
      .in_b      (ib),
      .in_mode   (im),
      .out_valid (ov),
      .out_ready (out_rdy),
      .out_sum   (os),
      .out_cout  (oc)
    );

    initial begin
      int sent, got, cyc, sel;
      logic last_acc;
      logic [63:0] ra, rb, m;
      logic [64:0] r;
      logic [W:0] e;
      iv = 1'b0; out_rdy = 1'b0; ia = '0; ib = '0; im = 1'b0;
      sent = 0; got = 0; cyc = 0; last_acc = 1'b0;
      m = {64{1'b1}} >> (64 - W);
      ra = '0; rb = '0;
      wait (rst_n === 1'b1);
      while (got < NRAND && cyc < 8 * NRAND) begin
        @(negedge clk);
        if (!iv || last_acc) begin
          if (sent < NRAND && $urandom_range(0, 3) != 0) begin
            ra = {$urandom, $urandom} & m;
            rb = {$urandom, $urandom} & m;
            sel = $urandom_range(0, 7);
            if (sel == 0) ra = m;
            else if (sel == 1) rb = m - ra;
            else if (sel == 2) rb = m;
            iv = 1'b1;
            ia = ra[W-1:0];
            ib = rb[W-1:0];
            im = $urandom_range(0, 1) == 1;
          end else begin
            iv = 1'b0;
          end
        end
        out_rdy = ($urandom_range(0, 3) != 0);
        #1;
        if (ov && out_rdy) begin
          if (exp_q.size() == 0) check("rand_spurious", ov, 0);
          else begin
            check($sformatf("rand_w%0d_s%0d", W, S), {oc, os}, exp_q.pop_front());
            got++;
          end
        end
        last_acc = iv && ir;
        if (last_acc) begin
          r = ref_add(ra, rb, im, W);
          e = {r[64], r[W-1:0]};
          exp_q.push_back(e);
          sent++;
        end
        cyc++;
      end
      check($sformatf("rand_count_w%0d_s%0d", W, S), got, NRAND);
      mark_done();
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] ta[8], tb_v[8];
    logic [16:0] bq[$];
    logic [16:0] e16;
    int sent, got, stale;

    rst_n = 1'b1; rst_n_dir = 1'b1;
    d_in_valid = 1'b0; d_out_ready = 1'b0; d_a = '0; d_b = '0; d_mode = 1'b0;
    #1 rst_n = 1'b0; rst_n_dir = 1'b0;
    #2;
    check("rst_out_valid", d_out_valid, 0);
    check("rst_out_sum", d_sum, 0);
    check("rst_out_cout", d_cout, 0);
    @(negedge clk);
    rst_n = 1'b1; rst_n_dir = 1'b1;
    #1 check("rst_in_ready", d_in_ready, 1);

    dir_txn("m0_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    dir_txn("m1_ffff_1", 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b0);
    dir_txn("m1_1234", 16'h1234, 16'hF00F, 1'b1, 16'h0244, 1'b0);
    dir_txn("m0_1234", 16'h1234, 16'hF00F, 1'b0, 16'h0243, 1'b1);
    dir_txn("m1_zero", 16'h8000, 16'h7FFF, 1'b1, EXP_EAC_ZERO, 1'b0);
    dir_txn("m1_ones", 16'hFFFF, 16'hFFFF, 1'b1, EXP_EAC_ZERO, 1'b0);
    dir_txn("m0_zero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);

    // Backpressure stream with alternating modes.
    for (int i = 0; i < 8; i++) begin
      ta[i] = 16'($urandom);
      tb_v[i] = 16'($urandom);
    end
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      if (sent < 8) begin
        d_in_valid = 1'b1; d_a = ta[sent]; d_b = tb_v[sent]; d_mode = sent[0];
      end else d_in_valid = 1'b0;
      d_out_ready = !(cyc >= 3 && cyc < 8);
      #1;
      if (cyc == 7) begin
        check("bp_in_ready_low", d_in_ready, 0);
        check("bp_out_valid_held", d_out_valid, 1);
      end
      if (d_out_valid) begin
        if (bq.size() == 0) check("bp_spurious", d_out_valid, 0);
        else begin
          check("bp_out", {d_cout, d_sum}, bq[0]);
          if (d_out_ready) begin
            e16 = bq.pop_front();
            got++;
          end
        end
      end
      if (d_in_valid && d_in_ready) begin
        bq.push_back(ref16(d_a, d_b, d_mode));
        sent++;
      end
    end
    check("bp_count", got, 8);

    // Reset with the pipe full.
    @(negedge clk);
    d_out_ready = 1'b0; d_in_valid = 1'b1; d_a = 16'h1111; d_b = 16'h2222; d_mode = 1'b0;
    @(negedge clk);
    d_a = 16'h0101; d_b = 16'h1010;
    @(negedge clk);
    d_in_valid = 1'b0;
    #1;
    check("pre_rst_valid", d_out_valid, 1);
    check("pre_rst_sum", d_sum, 16'h3333);
    #1 rst_n_dir = 1'b0;
    #1;
    check("mid_rst_valid", d_out_valid, 0);
    check("mid_rst_sum", d_sum, 0);
    check("mid_rst_cout", d_cout, 0);
    @(negedge clk);
    rst_n_dir = 1'b1; d_out_ready = 1'b1;
    #1 check("post_rst_in_ready", d_in_ready, 1);
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1 if (d_out_valid) stale++;
    end
    check("post_rst_no_stale", stale, 0);

    for (int i = 0; i < 30000 && done_cnt < 4; i++) @(negedge clk);
    check("rand_done", done_cnt, 4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
